// File: rtl/keypad_scanner_pkg.sv
// Shared types for the keypad scanner: matrix geometry and the per-frame scan result.
package keypad_scanner_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } res_kind_t;

    typedef struct packed {
        res_kind_t  kind;
        logic [3:0] code;
    } frame_res_t;

    // NONE always carries code 0 so whole-struct compares are meaningful.
    localparam frame_res_t RES_IDLE = '{kind: RES_NONE, code: 4'd0};

endpackage

// File: rtl/keypad_scanner_scan_timer.sv
// Row/digit strobe timer: dwell divider, 2-bit row index and active-low one-hot row decode.
module keypad_scanner_scan_timer
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 125000
) (
    input  logic               clock,
    input  logic               rst_n,
    output logic               o_tick,
    output logic [1:0]         o_row_idx,
    output logic               o_frame_end,
    output logic [KP_ROWS-1:0] o_row
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] r_div_cnt;
    logic [1:0]    r_row_idx;
    logic          w_tick;

    assign w_tick = (r_div_cnt == CW'(SCAN_DIV - 1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_row_idx <= 2'd0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_row_idx <= r_row_idx + 2'd1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_tick      = w_tick;
    assign o_row_idx   = r_row_idx;
    assign o_frame_end = w_tick & (r_row_idx == 2'd3);
    assign o_row       = ~(KP_ROWS'(1) << r_row_idx);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column sync, per-frame hit accumulation, debounce and
// single-pulse press reporting.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 125000,
    parameter int DEBOUNCE = 4
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic [KP_COLS-1:0] col,
    output logic [KP_ROWS-1:0] row,
    output logic [3:0]         key_code,
    output logic               key_valid,
    output logic               key_down
);

    localparam logic [3:0] DB = 4'(DEBOUNCE);

    logic               w_tick;
    logic               w_frame_end;
    logic [1:0]         w_row_idx;
    logic [KP_COLS-1:0] r_col_m;
    logic [KP_COLS-1:0] r_col_s;
    logic [1:0]         r_hits;
    logic [3:0]         r_code;
    logic [1:0]         w_hits_nxt;
    logic [3:0]         w_code_nxt;
    frame_res_t         w_res;
    frame_res_t         r_cand;
    frame_res_t         r_stable;
    frame_res_t         w_cand_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic               w_accept;

    keypad_scanner_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan_timer (
        .clock       (clock),
        .rst_n       (rst_n),
        .o_tick      (w_tick),
        .o_row_idx   (w_row_idx),
        .o_frame_end (w_frame_end),
        .o_row       (row)
    );

    // Released (pulled-up) is the safe reset value for the column lines.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_col_m <= '1;
            r_col_s <= '1;
        end else begin
            r_col_m <= col;
            r_col_s <= r_col_m;
        end
    end

    always_comb begin
        w_hits_nxt = r_hits;
        w_code_nxt = r_code;
        for (int c = 0; c < KP_COLS; c++) begin
            if (!r_col_s[c]) begin
                if (w_hits_nxt != 2'd2) w_hits_nxt = w_hits_nxt + 2'd1;
                w_code_nxt = {w_row_idx, 2'(c)};
            end
        end
    end

    always_comb begin
        w_res = RES_IDLE;
        if (w_hits_nxt == 2'd1) begin
            w_res = '{kind: RES_KEY, code: w_code_nxt};
        end else if (w_hits_nxt == 2'd2) begin
            w_res = '{kind: RES_MULTI, code: 4'd0};
        end
    end

    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        if (w_res.kind != RES_MULTI) begin
            if (w_res == r_cand) begin
                if (r_cnt != DB) w_cnt_nxt = r_cnt + 4'd1;
            end else begin
                w_cand_nxt = w_res;
                w_cnt_nxt  = 4'd1;
            end
        end
    end

    assign w_accept = (w_cnt_nxt == DB) && (w_cand_nxt != r_stable);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_hits <= 2'd0;
            r_code <= 4'd0;
        end else if (w_frame_end) begin
            r_hits <= 2'd0;
            r_code <= 4'd0;
        end else if (w_tick) begin
            r_hits <= w_hits_nxt;
            r_code <= w_code_nxt;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_cand    <= RES_IDLE;
            r_cnt     <= 4'd0;
            r_stable  <= RES_IDLE;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (w_frame_end) begin
                r_cand <= w_cand_nxt;
                r_cnt  <= w_cnt_nxt;
                if (w_accept) begin
                    r_stable <= w_cand_nxt;
                    if (w_cand_nxt.kind == RES_KEY) begin
                        key_code  <= w_cand_nxt.code;
                        key_valid <= 1'b1;
                        key_down  <= 1'b1;
                    end else begin
                        key_down  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: matrix model drives col, a scoreboard queue holds expected press codes.
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DB    = 3;
    localparam int FRAME = 4 * SD;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed = '0;
    logic        prev_valid = 1'b0;
    logic [3:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    // A pressed key shorts its row strobe onto its column line.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    // Pulse must arrive exactly n cycles after the call (scoreboard popped by the monitor).
    task automatic expect_pulse_at(input logic [3:0] code, input int n, input bit hold_down);
        exp_q.push_back(code);
        for (int i = 1; i < n; i++) begin
            step(1);
            if (hold_down) chk("hold_down", key_down, 1);
        end
        chk("pulse_not_early", exp_q.size(), 1);
        step(1);
        chk("pulse_on_time", exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clock) begin
        chk("row_onehot", 32'($countones(~row)), 1);
        if (key_valid === 1'b1) begin
            chk("pulse_width", prev_valid, 0);
            chk("pulse_down", key_down, 1);
            chk("pulse_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("pulse_code", key_code, exp_q.pop_front());
        end
        prev_valid = key_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_row;

        step(3);
        chk("rst_row", row, 4'b1110);
        chk("rst_code", key_code, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_down", key_down, 0);

        @(negedge clock);
        rst_n = 1'b1;
        for (int k = 1; k <= FRAME; k++) begin
            step(1);
            exp_row = ~(4'b0001 << ((k / SD) % 4));
            chk("row_seq", row, exp_row);
        end

        // Clean press of row 2 col 1, aligned to a frame boundary.
        pressed = 16'h0200;
        expect_pulse_at(4'd9, 3 * FRAME, 1'b0);
        chk("press_down", key_down, 1);
        chk("press_code", key_code, 9);

        pressed = '0;
        step(3 * FRAME - 1);
        chk("release_down_held", key_down, 1);
        step(1);
        chk("release_down_fell", key_down, 0);
        chk("release_code_kept", key_code, 9);

        for (int i = 0; i < 10; i++) begin
            pressed = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            step(FRAME);
        end
        chk("bounce_down", key_down, 0);
        pressed = 16'h0020;
        expect_pulse_at(4'd5, 3 * FRAME, 1'b0);

        pressed = 16'h8001;
        step(6 * FRAME);
        chk("multi_down", key_down, 1);
        chk("multi_code", key_code, 5);
        pressed = 16'h0001;
        expect_pulse_at(4'd0, 3 * FRAME, 1'b0);

        pressed = 16'h0008;
        expect_pulse_at(4'd3, 3 * FRAME, 1'b1);
        pressed = 16'h1000;
        expect_pulse_at(4'd12, 3 * FRAME, 1'b1);
        chk("change_code", key_code, 12);

        pressed = 16'h0080;
        step(2 * FRAME + 8);
        rst_n = 1'b0;
        #1;
        chk("arst_row", row, 4'b1110);
        chk("arst_code", key_code, 0);
        chk("arst_valid", key_valid, 0);
        chk("arst_down", key_down, 0);
        step(2);
        @(negedge clock);
        rst_n = 1'b1;
        expect_pulse_at(4'd7, 3 * FRAME, 1'b0);
        chk("arst_final_code", key_code, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low key matrix, debounces the result, and reports single key presses to the core. It is the input-side companion of the multiplexed seven-segment display driver. It strobes one matrix row at a time, as the display strobes one digit at a time, and reads the column lines back. The outputs are a key code, a one-cycle `key_valid` pulse per debounced press, and a `key_down` level.

## Interface
Parameters:
- `SCAN_DIV`, default 125000: clock cycles each row stays driven (400 Hz row rate at 50 MHz); legal range ≥ 2.
- `DEBOUNCE`, default 4: number of consecutive identical frames required before a change is accepted; legal range 1..15.

Ports:
- `clock`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `col`  in  4  matrix column lines; active-low (pulled up externally); asynchronous to `clock`.
- `row`  out  4  matrix row strobes; active-low, exactly one bit low at all times.
- `key_code`  out  4  last accepted key, `row_index*4 + col_index`.
- `key_valid`  out  1  one-cycle pulse when a new press is accepted.
- `key_down`  out  1  high while the accepted state is "a key is pressed".

## Operation
- **Input sync:** `col` passes through a 2-flop synchroniser (`col_s`) before any use.
- **Scan timer:** `div_cnt` counts 0..SCAN_DIV-1 and wraps. `tick` is high when `div_cnt == SCAN_DIV-1`.
- **Row sequencer:** `row_idx` (2 bits) advances 0→1→2→3→0 on `tick`. `row = ~(4'b0001 << row_idx)`.
- **Sampling:** on `tick`, the pressed columns of the current row (`~col_s`) are folded into frame accumulators:
  - `hits`: number of pressed contacts this frame, saturating at 2.
  - `code`: the last pressed position.
- **Frame result:** evaluated on the `tick` where `row_idx == 3`. That row's sample is included.
  - `hits == 0` → NONE.
  - `hits == 1` → KEY(code).
  - `hits >= 2` → MULTI.
  - Accumulators clear on the same edge.
- **Debounce,** on each frame result:
  - MULTI: ignored; the candidate and counter are unchanged.
  - Result equals `cand`: `cnt` increments, saturating at DEBOUNCE.
  - Result differs from `cand`: `cand` is set to the result and `cnt` to 1.
- **Acceptance:** when the updated `cnt == DEBOUNCE` and `cand != stable`, then `stable <= cand`.
  - If the new `stable` is KEY(k): `key_code <= k`, `key_valid <= 1`, `key_down <= 1`.
  - If the new `stable` is NONE: `key_down <= 0`; `key_code` holds its value; no pulse.
- **Direct key-to-key change** (KEY(a) stable, then KEY(b) accepted without NONE in between): produces a new pulse with code b.
- **Held key:** a held key produces exactly one pulse; there is no auto-repeat.

## Timing
- **Reset values:**
  - `row = 4'b1110`, `key_code = 0`, `key_valid = 0`, `key_down = 0`.
  - `div_cnt = 0`, `row_idx = 0`, accumulators clear.
  - `cand = NONE`, `cnt = 0`, `stable = NONE`.
- **Frame length:** 4*SCAN_DIV cycles.
- **Acceptance edge:** `key_valid`, `key_code` and `key_down` all update on the frame-end `tick` edge and are registered outputs. `key_valid` is high for exactly one cycle.
- **Worst-case press latency:** DEBOUNCE+1 frames + 2 sync cycles from a stable contact.
- **Column sampling:** `col_s` is sampled only in the last cycle of a row's dwell, so the column lines settle for SCAN_DIV-1 cycles.
- **Mid-frame press or release:** the partial frame is counted as whatever was sampled; debounce absorbs it.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronously). Any pending acceptance is lost, and scanning restarts at row 0.

## Structure
- **Shared package:**
  - `KP_ROWS = 4`, `KP_COLS = 4`.
  - The frame-result encoding: 2-bit kind `{NONE, KEY, MULTI}` plus a 4-bit code.
- **Sub-module `scan_timer`:** `div_cnt` plus `row_idx` plus the `row` decode, outputting `tick`, `row_idx` and `frame_end`. The display driver's digit multiplexer reuses the same block.
- **Remainder of `keypad_scanner`:** the synchroniser, accumulators and debounce registers.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3, giving a 16-cycle frame. Each scenario is one line: stimulus → required response.
- **Reset:** hold `rst_n` low → `row=1110`, all outputs 0. Release → `row` cycles 1110, 1101, 1011, 0111, advancing every 4 clocks.
- **Clean press:** model the matrix; press row 2 col 1 steadily → exactly one `key_valid` pulse with `key_code=9`, issued 3 frame-ends after the first full frame containing it; `key_down=1`. Release → `key_down` falls 3 frames later with no pulse, and `key_code` stays 9.
- **Bounce:** toggle key 5 present/absent on alternating frames for 10 frames → no `key_valid`, `key_down` stays 0. Then hold it steady → one pulse with code 5.
- **Multi-key:** hold keys 0 and 15 together for 6 frames → no pulse, state unchanged. Then release key 15 → one pulse with code 0 after 3 frames.
- **Key change:** hold key 3 until accepted, then switch directly to key 12 → a second pulse with code 12 and `key_down` stays 1 throughout.
- **Async reset mid-count:** assert `rst_n` after 2 stable frames of key 7 → outputs and row return to reset values within the same cycle. After release, the pulse for key 7 arrives only after a full new debounce.
